// File: rtl/debounce_pkg.sv
// Shared types and helpers for the time-multiplexed debounce scheduler.
package debounce_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_TIMING,
      S_COMMIT
   } dbs_state_t;

   function automatic int clocks_from_us(input int freq, input int us);
      return freq / 1_000_000 * us;
   endfunction

endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_idx
);

   int         j;
   logic [W-1:0] idx;

   // Walk offsets high to low so the smallest offset from ptr wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      idx       = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         idx = W'(j);
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/debounce_scheduler.sv
// One stability timer shared by NUM_CH synchronized inputs,
// handed out round-robin; commits emit a single edge pulse.
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter int NUM_CH           = 4,
   parameter int CLK_FREQUENCY    = 100_000_000,
   parameter int DEBOUNCE_TIME_US = 5000,
   parameter int SYNC_STAGES      = 2,
   parameter int IW               = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] sig_in,
   output logic [NUM_CH-1:0] debounced,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic              busy,
   output logic [IW-1:0]     active_ch
);

   localparam int DC = clocks_from_us(CLK_FREQUENCY, DEBOUNCE_TIME_US);
   localparam int CW = $clog2(DC);

   logic [NUM_CH-1:0] sync;
   logic [NUM_CH-1:0] req;
   logic              gnt_valid;
   logic [IW-1:0]     gnt_idx;
   logic [IW-1:0]     rr_q;
   logic [CW-1:0]     cnt_q;
   logic              tgt_q;
   logic              stable;
   logic              cnt_done;
   dbs_state_t        state_q;
   dbs_state_t        state_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
      logic [SYNC_STAGES-1:0] sh_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) sh_q <= '0;
         else        sh_q <= {sh_q[SYNC_STAGES-2:0], sig_in[i]};
      end
      assign sync[i] = sh_q[SYNC_STAGES-1];
   end

   assign req      = sync ^ debounced;
   assign stable   = (sync[active_ch] == tgt_q);
   assign cnt_done = (cnt_q == CW'(DC - 1));
   assign busy     = (state_q != S_IDLE);

   rr_arbiter #(
      .N (NUM_CH),
      .W (IW)
   ) u_arb (
      .req       (req),
      .ptr       (rr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (gnt_valid) state_d = S_TIMING;
         S_TIMING: begin
            if (!stable)       state_d = S_IDLE;
            else if (cnt_done) state_d = S_COMMIT;
         end
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_ch  <= '0;
         tgt_q      <= 1'b0;
         cnt_q      <= '0;
         rr_q       <= '0;
         debounced  <= '0;
         rise_pulse <= '0;
         fall_pulse <= '0;
      end else begin
         rise_pulse <= '0;
         fall_pulse <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (gnt_valid) begin
                  active_ch <= gnt_idx;
                  tgt_q     <= sync[gnt_idx];
                  cnt_q     <= '0;
               end
            end
            S_TIMING: begin
               // Pointer advances on abort too, so no channel starves.
               if (!stable || cnt_done) begin
                  rr_q <= (int'(active_ch) == NUM_CH - 1) ? '0 : active_ch + 1'b1;
               end
               if (stable && !cnt_done) cnt_q <= cnt_q + 1'b1;
            end
            S_COMMIT: begin
               debounced[active_ch] <= tgt_q;
               if (tgt_q) rise_pulse[active_ch] <= 1'b1;
               else       fall_pulse[active_ch] <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with a 1000-clock debounce window.
module tb_debounce_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sig_in = 4'h0;
   logic [3:0] debounced;
   logic [3:0] rise_pulse;
   logic [3:0] fall_pulse;
   logic       busy;
   logic [1:0] active_ch;

   int passed = 0;
   int total = 0;
   int rise_cnt [4];
   int fall_cnt [4];
   int multi_pulse = 0;
   int g3_cnt = 0;

   debounce_scheduler #(
      .NUM_CH           (4),
      .CLK_FREQUENCY    (100_000_000),
      .DEBOUNCE_TIME_US (10),
      .SYNC_STAGES      (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in),
      .debounced  (debounced),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .busy       (busy),
      .active_ch  (active_ch)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 4; i++) begin
         rise_cnt[i] = 0;
         fall_cnt[i] = 0;
      end
   end

   always @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (rise_pulse[i]) rise_cnt[i]++;
            if (fall_pulse[i]) fall_cnt[i]++;
         end
         if ($countones({rise_pulse, fall_pulse}) > 1) multi_pulse++;
         if (busy && active_ch == 2'd3) g3_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   initial begin
      // 1. reset, then clean rise on ch0
      rst_n  = 1'b0;
      sig_in = 4'hF;
      tick(3);
      chk("rst_deb", 32'(debounced), 32'h0);
      chk("rst_rise", 32'(rise_pulse), 32'h0);
      chk("rst_fall", 32'(fall_pulse), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_act", 32'(active_ch), 32'h0);
      sig_in = 4'h0;
      rst_n  = 1'b1;
      tick(5);
      sig_in[0] = 1'b1;
      tick(500);
      chk("t1_busy", 32'(busy), 32'h1);
      chk("t1_act", 32'(active_ch), 32'h0);
      tick(503);
      chk("t1_deb_early", 32'(debounced), 32'h0);
      tick(1);
      chk("t1_deb", 32'(debounced), 32'h1);
      chk("t1_rise", 32'(rise_pulse), 32'h1);
      tick(1);
      chk("t1_rise_end", 32'(rise_pulse), 32'h0);
      chk("t1_idle", 32'(busy), 32'h0);

      // 4. ch0 falls while ch3 glitches high for 20 cycles
      tick(5);
      sig_in[0] = 1'b0;
      tick(100);
      sig_in[3] = 1'b1;
      tick(20);
      sig_in[3] = 1'b0;
      tick(100);
      chk("t4_busy", 32'(busy), 32'h1);
      chk("t4_act", 32'(active_ch), 32'h0);
      tick(783);
      chk("t4_deb_early", 32'(debounced), 32'h1);
      tick(1);
      chk("t4_deb", 32'(debounced), 32'h0);
      chk("t4_fall", 32'(fall_pulse), 32'h1);
      tick(5);
      chk("t4_deb3", 32'(debounced), 32'h0);
      chk("t4_no_g3", 32'(g3_cnt), 32'h0);
      chk("t4_fall_cnt", 32'(fall_cnt[0]), 32'h1);

      // 2. ch2 bounces, then settles high
      sig_in[2] = 1'b1;
      tick(60);
      chk("t2_act", 32'(active_ch), 32'h2);
      sig_in[2] = 1'b0;
      tick(120);
      sig_in[2] = 1'b1;
      tick(250);
      sig_in[2] = 1'b0;
      tick(90);
      chk("t2_no_commit", 32'(rise_cnt[2]), 32'h0);
      sig_in[2] = 1'b1;
      tick(1003);
      chk("t2_deb_early", 32'(debounced), 32'h0);
      tick(1);
      chk("t2_deb", 32'(debounced), 32'h4);
      chk("t2_rise", 32'(rise_pulse), 32'h4);
      tick(5);
      chk("t2_rise_cnt", 32'(rise_cnt[2]), 32'h1);

      // 6. ch2 falls cleanly
      sig_in[2] = 1'b0;
      tick(1003);
      chk("t6_deb_early", 32'(debounced), 32'h4);
      tick(1);
      chk("t6_deb", 32'(debounced), 32'h0);
      chk("t6_fall", 32'(fall_pulse), 32'h4);
      chk("t6_rise", 32'(rise_pulse), 32'h0);
      tick(1);
      chk("t6_fall_end", 32'(fall_pulse), 32'h0);

      // 3. simultaneous rise on ch1..3 from a fresh pointer
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      sig_in = 4'b1110;
      tick(500);
      chk("t3_act1", 32'(active_ch), 32'h1);
      tick(504);
      chk("t3_deb1", 32'(debounced), 32'h2);
      chk("t3_rise1", 32'(rise_pulse), 32'h2);
      tick(500);
      chk("t3_act2", 32'(active_ch), 32'h2);
      tick(501);
      chk("t3_deb2_early", 32'(debounced), 32'h2);
      tick(1);
      chk("t3_deb2", 32'(debounced), 32'h6);
      tick(500);
      chk("t3_act3", 32'(active_ch), 32'h3);
      tick(502);
      chk("t3_deb3", 32'(debounced), 32'hE);
      chk("t3_rise3", 32'(rise_pulse), 32'h8);
      chk("onehot_pulses", 32'(multi_pulse), 32'h0);

      // 5. reset in the middle of ch1's timing
      sig_in = 4'h0;
      rst_n  = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      sig_in[1] = 1'b1;
      tick(503);
      chk("t5_busy", 32'(busy), 32'h1);
      chk("t5_act", 32'(active_ch), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t5_async_busy", 32'(busy), 32'h0);
      chk("t5_async_act", 32'(active_ch), 32'h0);
      chk("t5_async_deb", 32'(debounced), 32'h0);
      tick(3);
      rst_n = 1'b1;
      tick(1003);
      chk("t5_deb_early", 32'(debounced), 32'h0);
      tick(1);
      chk("t5_deb", 32'(debounced), 32'h2);
      chk("t5_rise", 32'(rise_pulse), 32'h2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
